multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/legv8_ctrl_pkg.sv | 41 ++++
 rtl/opcode_decode.sv | 26 ++
 rtl/multi_cycle_control.sv | 82 ++++++++
 tb/tb_multi_cycle_control.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared encodings for the multi-cycle LEGv8 controller
package legv8_ctrl_pkg;
  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXEC   = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;
  localparam logic [2:0] S_TRAP   = 3'b101;
  typedef enum logic [3:0] {
    C_R, C_RS, C_I, C_IS, C_LOAD, C_STORE, C_CBZ, C_CBNZ, C_BCOND, C_B, C_BL
  } inst_class_e;
  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CB  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [2:0] BR_NONE  = 3'b000;
  localparam logic [2:0] BR_B     = 3'b001;
  localparam logic [2:0] BR_CBZ   = 3'b010;
  localparam logic [2:0] BR_CBNZ  = 3'b011;
  localparam logic [2:0] BR_BCOND = 3'b100;
  localparam logic [2:0] BR_BL    = 3'b101;
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;
  function automatic logic [2:0] branch_code(input inst_class_e c);
    return c == C_B ? BR_B : c == C_CBZ ? BR_CBZ : c == C_CBNZ ? BR_CBNZ :
           c == C_BCOND ? BR_BCOND : c == C_BL ? BR_BL : BR_NONE;
  endfunction
endpackage

// File: rtl/opcode_decode.sv
// opcode_decode: classify an 11-bit LEGv8 opcode and flag illegal ones
module opcode_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output inst_class_e cls,
  output logic        legal
);
  // Priority match; flag-setting forms get their own class so SregUp can be derived later
  always_comb begin
    cls = C_R;
    legal = 1'b1;
    if (opcode == OP_ADD || opcode == OP_AND || opcode == OP_ORR) cls = C_R;
    else if (opcode == OP_SUB) cls = C_RS;
    else if (opcode[10:1] == OP_ADDI) cls = C_I;
    else if (opcode[10:1] == OP_SUBI) cls = C_IS;
    else if (opcode == OP_LDUR) cls = C_LOAD;
    else if (opcode == OP_STUR) cls = C_STORE;
    else if (opcode[10:3] == OP_CBZ) cls = C_CBZ;
    else if (opcode[10:3] == OP_CBNZ) cls = C_CBNZ;
    else if (opcode[10:3] == OP_BCOND) cls = C_BCOND;
    else if (opcode[10:5] == OP_B) cls = C_B;
    else if (opcode[10:5] == OP_BL) cls = C_BL;
    else legal = 1'b0;
  end
endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: Moore FSM sequencing a multi-cycle LEGv8 datapath
module multi_cycle_control
  import legv8_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        Reg2Loc,
  output logic        WRegLoc,
  output logic        ALUSrc,
  output logic        SregUp,
  output logic [1:0]  ALUOp,
  output logic [2:0]  BranchOp,
  output logic [1:0]  MemtoReg,
  output logic        trap,
  output logic [2:0]  state
);
  logic [2:0] state_q, state_d;
  inst_class_e cls_q, dec_cls;
  logic dec_legal, unused_inst;
  logic is_r, is_i, is_sub, is_load, is_store, is_cb, is_bl, is_br;
  logic f, e, m, w;
  opcode_decode u_dec (.opcode(inst[31:21]), .cls(dec_cls), .legal(dec_legal));
  assign unused_inst = ^inst[20:0];
  assign is_r     = cls_q == C_R || cls_q == C_RS;
  assign is_i     = cls_q == C_I || cls_q == C_IS;
  assign is_sub   = cls_q == C_RS || cls_q == C_IS;
  assign is_load  = cls_q == C_LOAD;
  assign is_store = cls_q == C_STORE;
  assign is_cb    = cls_q == C_CBZ || cls_q == C_CBNZ;
  assign is_bl    = cls_q == C_BL;
  assign is_br    = is_cb || is_bl || cls_q == C_B || cls_q == C_BCOND;
  // Next-state selection; mem_ready only matters in the two request states
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : (is_br && !is_bl) ? S_FETCH : S_WB;
      S_MEM:    state_d = !mem_ready ? S_MEM : is_load ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end
  // State and instruction class registers; class is captured only on a legal decode
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q <= C_R;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && dec_legal) cls_q <= dec_cls;
    end
  end
  assign f = !rst && state_q == S_FETCH;
  assign e = !rst && state_q == S_EXEC;
  assign m = !rst && state_q == S_MEM;
  assign w = !rst && state_q == S_WB;
  assign mem_req  = f | m;
  assign mem_sel  = m;
  assign mem_we   = m & is_store;
  assign IRWrite  = f & mem_ready;
  assign PCWrite  = (f & mem_ready) | (e & is_br);
  assign RegWrite = w;
  assign Reg2Loc  = e & (is_store | is_br);
  assign WRegLoc  = w & is_bl;
  assign ALUSrc   = e & (is_i | is_load | is_store);
  assign SregUp   = e & is_sub;
  assign ALUOp    = !e ? ALU_ADD : (is_r | is_i) ? ALU_R : is_cb ? ALU_CB : ALU_ADD;
  assign BranchOp = e ? branch_code(cls_q) : BR_NONE;
  assign MemtoReg = !w ? MTR_ALU : is_load ? MTR_MEM : is_bl ? MTR_PC : MTR_ALU;
  assign trap     = !rst && state_q == S_TRAP;
  assign state    = rst ? S_FETCH : state_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: scoreboard bench for the multi-cycle controller
module tb_multi_cycle_control;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic [31:0] inst = 32'h0;
  logic mem_req, mem_we, mem_sel, PCWrite, IRWrite, RegWrite, Reg2Loc, WRegLoc, ALUSrc, SregUp, trap;
  logic [1:0] ALUOp, MemtoReg;
  logic [2:0] BranchOp, state;
  multi_cycle_control dut (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .Reg2Loc(Reg2Loc),
    .WRegLoc(WRegLoc), .ALUSrc(ALUSrc), .SregUp(SregUp), .ALUOp(ALUOp),
    .BranchOp(BranchOp), .MemtoReg(MemtoReg), .trap(trap), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic r; logic m; logic [31:0] i; logic [20:0] e;} stim_t;
  stim_t sq[$];
  logic [20:0] sb[$];
  int n_cmp = 0, n_err = 0;
  localparam logic [31:0] ADD = 32'h8B030041, SUB = 32'hCB000000, SUBI = 32'hD1000000;
  localparam logic [31:0] LDUR = 32'hF8400041, STUR = 32'hF8000041, BL = 32'h94000010;
  localparam logic [9:0] NO = 10'b0000000000, FQ = 10'b1000000000, FR = 10'b1001100000;
  localparam logic [9:0] RW = 10'b0000010000, BRX = 10'b0001001000;
  // ctl bits: req we sel pcw irw rw r2l wrl alusrc sregup
  function automatic logic [20:0] ev(input logic [2:0] st, input logic [9:0] ctl,
      input logic [1:0] alu = 2'b00, input logic [2:0] br = 3'b000,
      input logic [1:0] mtr = 2'b00, input logic t = 1'b0);
    return {st, ctl, alu, br, mtr, t};
  endfunction
  function automatic logic [20:0] obs();
    return {state, mem_req, mem_we, mem_sel, PCWrite, IRWrite, RegWrite, Reg2Loc, WRegLoc,
            ALUSrc, SregUp, ALUOp, BranchOp, MemtoReg, trap};
  endfunction
  task automatic add(input logic r, input logic m, input logic [31:0] i, input logic [20:0] e);
    sq.push_back({r, m, i, e});
  endtask
  task automatic test_reset();
    stim_t s;
    logic [20:0] e;
    add(1, 1, ADD, ev(3'd0, NO));
    add(1, 1, ADD, ev(3'd0, NO));
    add(0, 0, ADD, ev(3'd0, FQ));
    for (int k = 0; sq.size() > 0; k++) begin
      s = sq.pop_front();
      rst = s.r; mem_ready = s.m; inst = s.i; sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL reset cyc%0d: got %h want %h", k, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_alu();
    stim_t s;
    logic [20:0] e;
    add(0, 1, ADD, ev(3'd0, FR));
    add(0, 1, ADD, ev(3'd1, NO));
    add(0, 0, ADD, ev(3'd2, NO, 2'b10));
    add(0, 0, ADD, ev(3'd4, RW));
    add(0, 0, SUBI, ev(3'd0, FQ));
    add(0, 1, SUBI, ev(3'd0, FR));
    add(0, 0, SUBI, ev(3'd1, NO));
    add(0, 0, 32'h0, ev(3'd2, 10'b0000000011, 2'b10));
    add(0, 0, 32'h0, ev(3'd4, RW));
    add(0, 1, SUB, ev(3'd0, FR));
    add(0, 0, SUB, ev(3'd1, NO));
    add(0, 0, SUB, ev(3'd2, 10'b0000000001, 2'b10));
    add(0, 0, SUB, ev(3'd4, RW));
    for (int k = 0; sq.size() > 0; k++) begin
      s = sq.pop_front();
      rst = s.r; mem_ready = s.m; inst = s.i; sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL alu cyc%0d: got %h want %h", k, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_mem();
    stim_t s;
    logic [20:0] e;
    add(0, 1, LDUR, ev(3'd0, FR));
    add(0, 0, LDUR, ev(3'd1, NO));
    add(0, 0, LDUR, ev(3'd2, 10'b0000000010));
    add(0, 0, LDUR, ev(3'd3, 10'b1010000000));
    add(0, 0, LDUR, ev(3'd3, 10'b1010000000));
    add(0, 1, LDUR, ev(3'd3, 10'b1010000000));
    add(0, 0, LDUR, ev(3'd4, RW, 2'b00, 3'b000, 2'b01));
    add(0, 1, STUR, ev(3'd0, FR));
    add(0, 0, STUR, ev(3'd1, NO));
    add(0, 0, STUR, ev(3'd2, 10'b0000001010));
    add(0, 0, STUR, ev(3'd3, 10'b1110000000));
    add(0, 1, STUR, ev(3'd3, 10'b1110000000));
    add(0, 0, STUR, ev(3'd0, FQ));
    add(0, 1, ADD, ev(3'd0, FR));
    add(0, 0, ADD, ev(3'd1, NO));
    add(0, 0, ADD, ev(3'd2, NO, 2'b10));
    add(0, 0, ADD, ev(3'd4, RW));
    for (int k = 0; sq.size() > 0; k++) begin
      s = sq.pop_front();
      rst = s.r; mem_ready = s.m; inst = s.i; sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL mem cyc%0d: got %h want %h", k, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_branch();
    stim_t s;
    logic [20:0] e;
    logic [31:0] bi [4] = '{32'hB5000041, 32'h14000000, 32'hB4000000, 32'h54000000};
    logic [1:0] ba [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
    logic [2:0] bb [4] = '{3'b011, 3'b001, 3'b010, 3'b100};
    for (int j = 0; j < 4; j++) begin
      add(0, 1, bi[j], ev(3'd0, FR));
      add(0, 0, bi[j], ev(3'd1, NO));
      add(0, 1, bi[j], ev(3'd2, BRX, ba[j], bb[j]));
    end
    add(0, 1, BL, ev(3'd0, FR));
    add(0, 0, BL, ev(3'd1, NO));
    add(0, 0, BL, ev(3'd2, BRX, 2'b00, 3'b101));
    add(0, 0, BL, ev(3'd4, 10'b0000010100, 2'b00, 3'b000, 2'b10));
    for (int k = 0; sq.size() > 0; k++) begin
      s = sq.pop_front();
      rst = s.r; mem_ready = s.m; inst = s.i; sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL branch cyc%0d: got %h want %h", k, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_trap_reset();
    stim_t s;
    logic [20:0] e;
    add(0, 0, ADD, ev(3'd0, FQ));
    add(0, 0, ADD, ev(3'd0, FQ));
    add(1, 1, ADD, ev(3'd0, NO));
    add(0, 0, ADD, ev(3'd0, FQ));
    add(0, 1, 32'h0, ev(3'd0, FR));
    add(0, 1, 32'h0, ev(3'd1, NO));
    for (int j = 0; j < 10; j++) add(0, j[0], (j == 5) ? ADD : 32'h0, ev(3'd5, NO, 2'b00, 3'b000, 2'b00, 1'b1));
    add(1, 0, 32'h0, ev(3'd0, NO));
    add(0, 0, 32'h0, ev(3'd0, FQ));
    add(0, 1, ADD, ev(3'd0, FR));
    add(0, 0, ADD, ev(3'd1, NO));
    add(0, 0, ADD, ev(3'd2, NO, 2'b10));
    add(0, 0, ADD, ev(3'd4, RW));
    for (int k = 0; sq.size() > 0; k++) begin
      s = sq.pop_front();
      rst = s.r; mem_ready = s.m; inst = s.i; sb.push_back(s.e);
      @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if (obs() !== e) begin n_err++; $display("FAIL trap_reset cyc%0d: got %h want %h", k, obs(), e); end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_trap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
